spi_regfile: RTL and testbench

SPI_REGFILE -- requirements
Module: spi_regfile

---
 rtl/spi_regfile.sv | 181 ++++++++++++++++++
 tb/tb_spi_regfile.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/spi_regfile.sv
// SPI mode-0 peripheral with a small write/read register file, driven from a fast system clock.
// Optional readback path: define SPI_REGFILE_READBACK_EN to compile in the CIPO shifter.
module spi_regfile #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       nCS,
  input  logic                       SCLK,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state_reg, state_next;

  logic [1:0]         ncs_sync_reg, sclk_sync_reg, copi_sync_reg;
  logic               ncs_prev_reg, sclk_prev_reg;
  logic [1:0]         settle_reg;
  logic               armed_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [FRAME_W-1:0] shift_reg;
  logic               long_reg;

  logic ncs_s, sclk_s, copi_s, ncs_rise, ncs_fall, sclk_rise;
  logic [FRAME_W-1:0] shift_next;
  logic               frame_rw, addr_ok, commit;
  logic [ADDR_W-1:0]  frame_addr;
  logic [DATA_W-1:0]  frame_data;

  assign ncs_s  = ncs_sync_reg[1];
  assign sclk_s = sclk_sync_reg[1];
  assign copi_s = copi_sync_reg[1];

  // A fall is only honoured once nCS has been seen high after reset, so a
  // frame interrupted by reset cannot resume without a fresh chip-select.
  assign ncs_fall  = armed_reg & ncs_prev_reg & ~ncs_s;
  assign ncs_rise  = ~ncs_prev_reg & ncs_s;
  assign sclk_rise = ~sclk_prev_reg & sclk_s;

  assign shift_next = {shift_reg[FRAME_W-2:0], copi_s};
  assign frame_rw   = shift_reg[FRAME_W-1];
  assign frame_addr = shift_reg[DATA_W +: ADDR_W];
  assign frame_data = shift_reg[DATA_W-1:0];
  assign addr_ok    = {1'b0, frame_addr} < NUM_REGS_L;
  assign commit     = ncs_rise && (state_reg == DONE) && !long_reg && frame_rw && addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_sync_reg  <= 2'b11;
      sclk_sync_reg <= 2'b00;
      copi_sync_reg <= 2'b00;
      ncs_prev_reg  <= 1'b1;
      sclk_prev_reg <= 1'b0;
      settle_reg    <= 2'd0;
      armed_reg     <= 1'b0;
    end else begin
      ncs_sync_reg  <= {ncs_sync_reg[0], nCS};
      sclk_sync_reg <= {sclk_sync_reg[0], SCLK};
      copi_sync_reg <= {copi_sync_reg[0], COPI};
      ncs_prev_reg  <= ncs_s;
      sclk_prev_reg <= sclk_s;
      if (settle_reg != 2'd2) settle_reg <= settle_reg + 2'd1;
      armed_reg     <= armed_reg | (ncs_s & (settle_reg == 2'd2));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (ncs_rise) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (ncs_fall) state_next = CMD;
        CMD:  if (sclk_rise && cnt_reg == CNT_W'(ADDR_W)) state_next = DATA;
        DATA: if (sclk_rise && cnt_reg == CNT_W'(FRAME_W-1)) state_next = DONE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      shift_reg <= '0;
      long_reg  <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      if (state_reg == IDLE && ncs_fall) begin
        cnt_reg   <= '0;
        shift_reg <= '0;
        long_reg  <= 1'b0;
      end else if (sclk_rise && (state_reg == CMD || state_reg == DATA)) begin
        shift_reg <= shift_next;
        cnt_reg   <= cnt_reg + CNT_W'(1);
      end else if (sclk_rise && state_reg == DONE) begin
        long_reg  <= 1'b1;
      end
      if (ncs_rise) begin
        case (state_reg)
          CMD, DATA: frame_err <= 1'b1;
          DONE: begin
            if (long_reg || (frame_rw && !addr_ok)) begin
              frame_err <= 1'b1;
            end else if (frame_rw) begin
              wr_pulse <= 1'b1;
              wr_addr  <= frame_addr;
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] data_reg;
    always_ff @(posedge clk) begin
      if (rst)                                         data_reg <= '0;
      else if (commit && frame_addr == ADDR_W'(gi))    data_reg <= frame_data;
    end
    assign regs_out[gi*DATA_W +: DATA_W] = data_reg;
  end

`ifdef SPI_REGFILE_READBACK_EN
  logic [DATA_W-1:0] out_shift_reg, rd_data;
  logic              read_reg, sclk_fall, cmd_done;
  logic [ADDR_W-1:0] rd_addr;

  assign sclk_fall = sclk_prev_reg & ~sclk_s;
  assign cmd_done  = !ncs_rise && state_reg == CMD && sclk_rise && cnt_reg == CNT_W'(ADDR_W);
  assign rd_addr   = shift_next[ADDR_W-1:0];

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_addr == ADDR_W'(i)) rd_data = regs_out[i*DATA_W +: DATA_W];
  end

  // The falling edge straight after the last command bit must not shift:
  // the MSB has to survive until the first data-phase rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_shift_reg <= '0;
      read_reg      <= 1'b0;
    end else if (cmd_done) begin
      read_reg      <= ~shift_next[ADDR_W];
      out_shift_reg <= rd_data;
    end else if (state_reg == DATA && sclk_fall && cnt_reg > CNT_W'(ADDR_W+1)) begin
      out_shift_reg <= {out_shift_reg[DATA_W-2:0], 1'b0};
    end
  end

  assign CIPO    = (state_reg == DATA) & read_reg & out_shift_reg[DATA_W-1];
  assign cipo_oe = ~ncs_s;
`else
  assign CIPO    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Scoreboard bench for spi_regfile: directed SPI frames, expected events queued, monitor pops on pulses.
module tb_spi_regfile;
  localparam int DATA_W = 8, ADDR_W = 7, NUM_REGS = 5;

  logic clk = 1'b0, rst = 1'b1, nCS = 1'b1, SCLK = 1'b0, COPI = 1'b0;
  logic CIPO, cipo_oe, wr_pulse, frame_err;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic [ADDR_W-1:0] wr_addr;

  spi_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .nCS(nCS), .SCLK(SCLK), .COPI(COPI),
    .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_out(regs_out),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

`ifdef SPI_REGFILE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    bit                         is_err;
    logic [ADDR_W-1:0]          addr;
    logic [NUM_REGS*DATA_W-1:0] regs;
  } exp_t;

  exp_t exp_q[$];
  bit   cipo_q[$];
  int   checks = 0, errors = 0;
  logic [DATA_W-1:0] model [NUM_REGS];

  function automatic logic [NUM_REGS*DATA_W-1:0] flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model[i];
    return f;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    model[a] = d;
    exp_q.push_back('{1'b0, a, flat()});
  endtask

  task automatic expect_err();
    exp_q.push_back('{1'b1, '0, flat()});
  endtask

  // Sends the low n bits of 'bits' MSB first; optional reset pulse before bit rst_at.
  task automatic send(input logic [23:0] bits, input int n, input int gap,
                      input bit rd_chk, input logic [7:0] rd_exp, input int rst_at);
    nCS = 1'b0;
    clks(4);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        clks(3);
        rst = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
      end
      COPI = bits[n-1-i];
      clks(5);
      if (rd_chk && i == ADDR_W + 1)
        for (int j = 7; j >= 0; j--) cipo_q.push_back(rd_exp[j]);
      SCLK = 1'b1;
      clks(5);
      SCLK = 1'b0;
    end
    clks(5);
    nCS = 1'b1;
    clks(gap);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (wr_pulse || frame_err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event wr_pulse=%0b frame_err=%0b wr_addr=%0h", wr_pulse, frame_err, wr_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (frame_err !== e.is_err || wr_pulse !== !e.is_err ||
            (!e.is_err && wr_addr !== e.addr) || regs_out !== e.regs) begin
          errors++;
          $display("FAIL event got err=%0b wr=%0b addr=%0h regs=%0h want err=%0b addr=%0h regs=%0h",
                   frame_err, wr_pulse, wr_addr, regs_out, e.is_err, e.addr, e.regs);
        end else begin
          $display("event err=%0b addr=%0h regs=%0h", frame_err, wr_addr, regs_out);
        end
      end
    end
  end

  always @(posedge SCLK) begin
    if (cipo_q.size() > 0) begin
      bit b;
      b = cipo_q.pop_front();
      checks++;
      if (CIPO !== b || cipo_oe !== RB) begin
        errors++;
        $display("FAIL cipo_bit got=%0b oe=%0b want=%0b oe=%0b", CIPO, cipo_oe, b, RB);
      end else begin
        $display("cipo bit %0b", CIPO);
      end
    end
  end

  initial begin
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    clks(4);
    chk("reset_regs_out", 64'(regs_out), 64'h0);
    chk("reset_wr_pulse", 64'(wr_pulse), 64'h0);
    chk("reset_frame_err", 64'(frame_err), 64'h0);
    chk("reset_wr_addr", 64'(wr_addr), 64'h0);
    chk("reset_cipo", 64'(CIPO), 64'h0);
    rst = 1'b0;
    clks(6);

    expect_wr(7'd1, 8'hA5); send(24'h0081A5, 16, 10, 0, 8'h00, -1);
    expect_err();           send(24'h00873C, 16, 10, 0, 8'h00, -1);
    expect_err();           send(24'h000825, 12, 10, 0, 8'h00, -1);
    expect_err();           send(24'h0104AA, 17, 10, 0, 8'h00, -1);
    expect_wr(7'd4, 8'h5A); send(24'h00845A, 16, 10, 0, 8'h00, -1);
    send(24'h000400, 16, 10, 1, RB ? 8'h5A : 8'h00, -1);
    expect_wr(7'd2, 8'hE7); send(24'h0082E7, 16, 10, 0, 8'h00, -1);
    expect_err();           send(24'h008599, 16, 10, 0, 8'h00, -1);
    send(24'h000900, 16, 10, 1, 8'h00, -1);
    send(24'h008077, 16, 10, 0, 8'h00, 10);
    chk("after_reset_abort_regs", 64'(regs_out), 64'(flat()));
    expect_wr(7'd0, 8'hC3); send(24'h0080C3, 16, 10, 0, 8'h00, -1);
    expect_wr(7'd3, 8'h11); send(24'h008311, 16, 4, 0, 8'h00, -1);
    expect_wr(7'd4, 8'h22); send(24'h008422, 16, 20, 0, 8'h00, -1);

    chk("pending_events", 64'(exp_q.size()), 64'h0);
    chk("final_regs_out", 64'(regs_out), 64'h22_11_00_00_C3);
    chk("final_wr_addr", 64'(wr_addr), 64'h4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
